// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between the register-file read
// path (1 byte) and the ALU result path (2 bytes, LSB first). Each source has
// a one-deep pending buffer. A round-robin arbiter picks the next buffer, and
// a four-state sequencer strobes its bytes into the TX using the TX_BUSY
// handshake.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable the accept watchdog.
// The watchdog re-strobes a byte the TX has not accepted and pulses TX_ERR.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64  // legal range 2..255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RF_RD_VALID,
  input  logic [7:0]  RF_RD_DATA,
  input  logic        ALU_VALID,
  input  logic [15:0] ALU_DATA,
  input  logic        TX_BUSY,
  output logic        TX_VALID,
  output logic [7:0]  TX_DATA,
  output logic        ARB_BUSY,
  output logic [1:0]  DROP,
  output logic        TX_ERR
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACC, WAIT_DONE} state_e;
  typedef enum logic {SRC_RF = 1'b0, SRC_ALU = 1'b1} src_e;

  state_e      state, nxt_state;
  src_e        last, gnt, nxt_gnt;
  logic        pend_rf, pend_alu;
  logic [7:0]  rf_data;
  logic [15:0] alu_data;
  logic [15:0] shreg, nxt_shreg;   // bytes still to send, current byte in [7:0]
  logic [1:0]  cnt, nxt_cnt;       // bytes remaining, including the current one
  logic        grant_take, clr_rf, clr_alu;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog;
  logic       timeout;
`endif

  assign ARB_BUSY = (state != IDLE);

  // Next-state, arbitration and byte-sequencing decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    nxt_state  = state;
    nxt_shreg  = shreg;
    nxt_cnt    = cnt;
    nxt_gnt    = gnt;
    grant_take = 1'b0;
    clr_rf     = 1'b0;
    clr_alu    = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    timeout    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (pend_rf || pend_alu) begin
          grant_take = 1'b1;
          nxt_state  = SEND;
          // RF wins when it is alone, or on a tie when ALU was served last.
          if (pend_rf && (!pend_alu || last == SRC_ALU)) begin
            nxt_gnt   = SRC_RF;
            nxt_shreg = {8'h00, rf_data};
            nxt_cnt   = 2'd1;
          end else begin
            nxt_gnt   = SRC_ALU;
            nxt_shreg = alu_data;
            nxt_cnt   = 2'd2;
          end
        end
      end
      SEND: nxt_state = WAIT_ACC;
      WAIT_ACC: begin
        if (TX_BUSY) begin
          nxt_state = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (wdog == WDOG_LAST) begin
          timeout   = 1'b1;
          nxt_state = SEND;          // shreg untouched: same byte re-strobed
`endif
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (cnt > 2'd1) begin
            nxt_shreg = {8'h00, shreg[15:8]};
            nxt_cnt   = cnt - 2'd1;
            nxt_state = SEND;
          end else begin
            nxt_cnt   = 2'd0;
            clr_rf    = (gnt == SRC_RF);
            clr_alu   = (gnt == SRC_ALU);
            nxt_state = IDLE;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Sequencer state, arbiter history and the registered TX strobe/byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      last     <= SRC_ALU;
      gnt      <= SRC_RF;
      shreg    <= '0;
      cnt      <= '0;
      TX_VALID <= 1'b0;
      TX_DATA  <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state    <= nxt_state;
      shreg    <= nxt_shreg;
      cnt      <= nxt_cnt;
      gnt      <= nxt_gnt;
      if (grant_take) last <= nxt_gnt;
      TX_VALID <= (nxt_state == SEND);
      if (nxt_state == SEND) TX_DATA <= nxt_shreg[7:0];
    end
  end

  // One-deep pending buffers; a request arriving while full is dropped
  // unless it lands on the very edge that frees the buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_rf  <= 1'b0;
      pend_alu <= 1'b0;
      rf_data  <= 8'h00;
      alu_data <= 16'h0000;
      DROP     <= 2'b00;
    end else begin
      if (RF_RD_VALID && (!pend_rf || clr_rf)) begin
        rf_data <= RF_RD_DATA;
        pend_rf <= 1'b1;
      end else if (clr_rf) begin
        pend_rf <= 1'b0;
      end
      if (ALU_VALID && (!pend_alu || clr_alu)) begin
        alu_data <= ALU_DATA;
        pend_alu <= 1'b1;
      end else if (clr_alu) begin
        pend_alu <= 1'b0;
      end
      DROP <= {ALU_VALID && pend_alu && !clr_alu,
               RF_RD_VALID && pend_rf && !clr_rf};
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Accept watchdog: restarts on every entry to WAIT_ACC, counts while there.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdog   <= 8'd0;
      TX_ERR <= 1'b0;
    end else begin
      if (state != WAIT_ACC && nxt_state == WAIT_ACC) wdog <= 8'd0;
      else if (state == WAIT_ACC)                      wdog <= wdog + 8'd1;
      TX_ERR <= timeout;
    end
  end
`else
  assign TX_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. A behavioural UART TX model raises BUSY
// two cycles after each strobe and holds it for 11 cycles. It can ignore one
// chosen strobe. A negedge monitor logs strobes, BUSY falls, DROP and TX_ERR.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  logic        CLK, RST;
  logic        RF_RD_VALID, ALU_VALID;
  logic [7:0]  RF_RD_DATA;
  logic [15:0] ALU_DATA;
  logic        TX_BUSY, TX_VALID, ARB_BUSY, TX_ERR;
  logic [7:0]  TX_DATA;
  logic [1:0]  DROP;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // TX model state
  bit tx_pipe    = 1'b0;
  int tx_bcnt    = 0;
  int tx_seen    = 0;
  int ignore_idx = -1;
  bit model_rst  = 1'b0;

  // Monitor logs
  logic [7:0] sq_data[$];
  int         sq_cyc[$];
  int         bfall_q[$];
  int         arb_fall_cyc = -1;
  int         drop_cnt = 0;
  logic [1:0] drop_val = 2'b00;
  int         err_cnt = 0;
  int         err_cyc = -1;
  logic       prev_busy = 1'b0, prev_arb = 1'b0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST),
    .RF_RD_VALID(RF_RD_VALID), .RF_RD_DATA(RF_RD_DATA),
    .ALU_VALID(ALU_VALID), .ALU_DATA(ALU_DATA),
    .TX_BUSY(TX_BUSY), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .ARB_BUSY(ARB_BUSY), .DROP(DROP), .TX_ERR(TX_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // UART TX model: a strobe seen at edge e gives BUSY high from edge e+1 for 11 cycles.
  initial begin
    logic v;
    TX_BUSY = 1'b0;
    forever begin
      @(posedge CLK);
      v = TX_VALID;
      #1;
      if (model_rst) begin
        tx_pipe = 1'b0;
        tx_bcnt = 0;
        TX_BUSY = 1'b0;
      end else begin
        if (tx_bcnt > 0) begin
          tx_bcnt--;
          if (tx_bcnt == 0) TX_BUSY = 1'b0;
        end
        if (tx_pipe) begin
          tx_pipe = 1'b0;
          TX_BUSY = 1'b1;
          tx_bcnt = 11;
        end
        if (v) begin
          if (tx_seen != ignore_idx) tx_pipe = 1'b1;
          tx_seen++;
        end
      end
    end
  end

  // Monitor, sampling mid-cycle.
  initial forever begin
    @(negedge CLK);
    if (TX_VALID) begin
      sq_data.push_back(TX_DATA);
      sq_cyc.push_back(cyc);
    end
    if (prev_busy && !TX_BUSY) bfall_q.push_back(cyc);
    if (prev_arb && !ARB_BUSY) arb_fall_cyc = cyc;
    if (DROP != 2'b00) begin
      drop_cnt++;
      drop_val = DROP;
    end
    if (TX_ERR) begin
      err_cnt++;
      err_cyc = cyc;
    end
    prev_busy = TX_BUSY;
    prev_arb  = ARB_BUSY;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t want < 200000", $time);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int sdat(input int i);
    return (i < sq_data.size()) ? int'(sq_data[i]) : -1;
  endfunction

  function automatic int scyc(input int i);
    return (i < sq_cyc.size()) ? sq_cyc[i] : -1;
  endfunction

  function automatic int bfall(input int i);
    return (i < bfall_q.size()) ? bfall_q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input bit rf, input bit alu, input logic [7:0] rd, input logic [15:0] ad);
    RF_RD_VALID = rf;
    RF_RD_DATA  = rd;
    ALU_VALID   = alu;
    ALU_DATA    = ad;
    tick(1);
    RF_RD_VALID = 1'b0;
    ALU_VALID   = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_tx_valid"}, int'(TX_VALID), 0);
    check({pfx, "_tx_data"},  int'(TX_DATA),  0);
    check({pfx, "_arb_busy"}, int'(ARB_BUSY), 0);
    check({pfx, "_drop"},     int'(DROP),     0);
    check({pfx, "_tx_err"},   int'(TX_ERR),   0);
  endtask

  initial begin
    int b, bf, t0, dc, ec, k;
    RST = 1'b1;
    RF_RD_VALID = 1'b0; RF_RD_DATA = 8'h00;
    ALU_VALID = 1'b0;   ALU_DATA = 16'h0000;
    #2;
    check_outputs_zero("reset");
    tick(2);
    RST = 1'b0;
    tick(2);

    // Single RF request
    b = sq_data.size(); bf = bfall_q.size(); t0 = cyc;
    pulse(1'b1, 1'b0, 8'hA5, 16'h0000);
    tick(40);
    check("rf_strobe_count", sq_data.size(), b + 1);
    check("rf_data", sdat(b), 'hA5);
    check("rf_strobe_latency", scyc(b), t0 + 2);
    check("rf_arb_fall", arb_fall_cyc, bfall(bf) + 1);
    check("rf_idle_after", int'(ARB_BUSY), 0);

    // ALU word, LSB first, second strobe one cycle after BUSY falls
    b = sq_data.size(); bf = bfall_q.size();
    pulse(1'b0, 1'b1, 8'h00, 16'h1234);
    tick(60);
    check("alu_strobe_count", sq_data.size(), b + 2);
    check("alu_byte0", sdat(b), 'h34);
    check("alu_byte1", sdat(b + 1), 'h12);
    check("alu_gap", scyc(b + 1), bfall(bf) + 1);

    // Tie with last=ALU: RF first
    b = sq_data.size();
    pulse(1'b1, 1'b1, 8'h11, 16'hBEEF);
    tick(80);
    check("tie1_count", sq_data.size(), b + 3);
    check("tie1_b0", sdat(b), 'h11);
    check("tie1_b1", sdat(b + 1), 'hEF);
    check("tie1_b2", sdat(b + 2), 'hBE);

    // Lone RF makes RF the last served; the next tie then goes to ALU
    b = sq_data.size();
    pulse(1'b1, 1'b0, 8'h33, 16'h0000);
    tick(40);
    pulse(1'b1, 1'b1, 8'h22, 16'hCAFE);
    tick(80);
    check("tie2_count", sq_data.size(), b + 4);
    check("tie2_rf_alone", sdat(b), 'h33);
    check("tie2_b0", sdat(b + 1), 'hFE);
    check("tie2_b1", sdat(b + 2), 'hCA);
    check("tie2_b2", sdat(b + 3), 'h22);

    // Drop: second RF request while the first is still pending
    b = sq_data.size(); dc = drop_cnt;
    pulse(1'b1, 1'b0, 8'h01, 16'h0000);
    pulse(1'b1, 1'b0, 8'h02, 16'h0000);
    tick(40);
    check("drop_cycles", drop_cnt, dc + 1);
    check("drop_value", int'(drop_val), 1);
    check("drop_strobe_count", sq_data.size(), b + 1);
    check("drop_kept_data", sdat(b), 'h01);

    // Accept watchdog: TX ignores the next strobe
    b = sq_data.size(); ec = err_cnt;
    ignore_idx = tx_seen;
    pulse(1'b1, 1'b0, 8'h5A, 16'h0000);
    tick(60);
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("wdog_err_count", err_cnt, ec + 1);
    check("wdog_strobe_count", sq_data.size(), b + 2);
    check("wdog_byte_first", sdat(b), 'h5A);
    check("wdog_byte_retry", sdat(b + 1), 'h5A);
    check("wdog_retry_spacing", scyc(b + 1), scyc(b) + 5);
    check("wdog_err_with_retry", err_cyc, scyc(b + 1));
    check("wdog_frame_done", int'(ARB_BUSY), 0);
`else
    check("nowdog_err_count", err_cnt, ec);
    check("nowdog_strobe_count", sq_data.size(), b + 1);
    check("nowdog_stuck_busy", int'(ARB_BUSY), 1);
    check("nowdog_tx_err", int'(TX_ERR), 0);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    tick(2);
`endif

    // Asynchronous reset during WAIT_DONE of the first ALU byte
    pulse(1'b0, 1'b1, 8'h00, 16'h5678);
    k = 0;
    while (!TX_BUSY && k < 50) begin
      tick(1);
      k++;
    end
    check("rstmid_busy_seen", int'(TX_BUSY), 1);
    tick(2);
    check("rstmid_in_frame", int'(ARB_BUSY), 1);
    #3;
    RST = 1'b1;
    model_rst = 1'b1;
    #1;
    check_outputs_zero("rstmid");
    repeat (2) @(posedge CLK);
    #3;
    model_rst = 1'b0;
    RST = 1'b0;
    tick(1);
    b = sq_data.size();
    tick(30);
    check("post_rst_no_strobe", sq_data.size(), b);
    check("post_rst_idle", int'(ARB_BUSY), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Sequencer and arbiter that shares the single UART transmitter between two result sources: the register-file read path (8-bit) and the ALU result path (16-bit, sent as two bytes).
- Captures each source's result into a one-deep pending buffer.
- Arbitrates round-robin between the buffers.
- Feeds bytes to the UART TX one at a time using its DATA_VALID/BUSY handshake.
- Sits between the system controller's result outputs and the UART TX input. TX_BUSY is already in the CLK domain.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: accept-watchdog limit in CLK cycles, legal range 2..255. Used only when UART_TX_ARB_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- RF_RD_VALID  in  1  one-cycle pulse: RF_RD_DATA is valid.
- RF_RD_DATA  in  8  register-file read byte.
- ALU_VALID  in  1  one-cycle pulse: ALU_DATA is valid.
- ALU_DATA  in  16  ALU result.
- TX_BUSY  in  1  UART TX busy, registered inside the TX.
- TX_VALID  out  1  registered one-cycle byte-strobe to the UART TX.
- TX_DATA  out  8  registered byte; held stable from the strobe until the next strobe.
- ARB_BUSY  out  1  high whenever the state is not IDLE.
- DROP  out  2  one-cycle pulse when a request is lost: bit0 = RF, bit1 = ALU.
- TX_ERR  out  1  one-cycle pulse on watchdog expiry.

## Operation
Pending buffers:
- Each source has pend_n plus a data register.
- VALID with pend_n=0: capture data, set pend_n.
- VALID with pend_n=1: discard the new data, pulse DROP[n] next cycle, keep the old data.
- VALID arriving on the same edge that clears pend_n: the new data is captured, pend_n stays 1, no DROP.

Arbiter:
- Round-robin on a last-served bit `last`; reset value is ALU, so RF wins the first tie.
- If only one buffer is pending, it is granted.
- On a tie, the source other than `last` is granted.
- `last` updates on grant.

FSM (IDLE, SEND, WAIT_ACC, WAIT_DONE):
- IDLE: any pending → grant, load the byte shift register (RF: 1 byte; ALU: 2 bytes, LSB first), go to SEND.
- SEND: TX_VALID=1 and TX_DATA=current byte for exactly this cycle → WAIT_ACC.
- WAIT_ACC: stay until TX_BUSY=1 → WAIT_DONE.
- WAIT_DONE: stay until TX_BUSY=0.
  - If bytes remain: shift to the next byte → SEND.
  - Otherwise: clear the granted pend_n → IDLE.

General rules:
- TX_VALID is never asserted outside SEND.
- Bytes of one ALU word are never interleaved with another source's bytes.

Reset (asynchronous, any time including mid-frame):
- State IDLE, pend_n=0, `last`=ALU, byte count 0.
- TX_VALID=0, TX_DATA=0x00, ARB_BUSY=0, DROP=0, TX_ERR=0.
- No partial byte sequence resumes after reset.

## Timing
- RF_RD_VALID at edge t: pend set at t+1, TX_VALID high in cycle t+2.
- UART TX registers BUSY, so TX_BUSY rises 2 cycles after the strobe. WAIT_ACC therefore lasts ≥2 cycles.
- Byte-to-byte gap within an ALU word: TX_BUSY falls at edge k, the second strobe is at cycle k+1.
- Back-to-back requests: IDLE lasts exactly 1 cycle between the completion of one request and the SEND of the next.
- DROP and TX_ERR are registered, one cycle wide.

## Configuration
- UART_TX_ARB_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entry to WAIT_ACC and increments each WAIT_ACC cycle.
  - When it reaches TIMEOUT_CYCLES-1 with TX_BUSY still 0: pulse TX_ERR, return to SEND, re-strobe the same byte.
  - Retries are unlimited.
- Not defined:
  - No watchdog; WAIT_ACC waits indefinitely.
  - TX_ERR is tied to 0.

## Test plan
- Single RF request: RF_RD_VALID with 0xA5 at t0, TX model raises BUSY 2 cycles after strobe for 11 cycles → one TX_VALID at t2 with TX_DATA=0xA5; ARB_BUSY falls one cycle after BUSY drops.
- ALU word: ALU_DATA=0x1234 → strobes 0x34 then 0x12; second strobe exactly 1 cycle after TX_BUSY falls.
- Tie and fairness:
  - RF 0x11 and ALU 0xBEEF pulse in the same cycle → order 0x11, 0xEF, 0xBE.
  - Repeated tie (RF 0x22, ALU 0xCAFE) → ALU first: 0xFE, 0xCA, 0x22.
- Drop: two RF pulses (0x01, 0x02) while the first is pending → DROP=2'b01 for one cycle; only 0x01 is transmitted.
- Timeout (macro defined, TIMEOUT_CYCLES=4):
  - TX model ignores the first strobe → TX_ERR pulse and a second strobe with the identical byte; the frame then completes.
  - Macro undefined → FSM stays in WAIT_ACC and TX_ERR stays 0.
- Reset mid-frame: assert RST during WAIT_DONE of the first ALU byte → all outputs 0 immediately. After release with TX_BUSY=0 and no requests, TX_VALID stays 0.
